// File: rtl/sram22_req_ctrl_pkg.sv
// Shared constants and the request record for the SRAM22 request controller.
package sram22_ctrl_pkg;

    localparam int SRAM22_DATA_W      = 32;
    localparam int SRAM22_ADDR_W      = 8;
    localparam int SRAM22_WMASK_W     = SRAM22_DATA_W / 8;
    localparam int SRAM22_RESP_DEPTH  = 4;

    typedef struct packed {
        logic                      we;
        logic [SRAM22_WMASK_W-1:0] wmask;
        logic [SRAM22_ADDR_W-1:0]  addr;
        logic [SRAM22_DATA_W-1:0]  wdata;
    } req_t;

endpackage

// File: rtl/sram22_req_ctrl_if.sv
// Request and response handshake bundle between a requester and the SRAM22 controller.
interface sram22_req_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [WMASK_WIDTH-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [DATA_WIDTH-1:0]  resp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram22_resp_fifo.sv
// Read-response FIFO: power-of-two depth, registered occupancy exported for credit accounting.
module sram22_resp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_W-1:0]      count_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pop;

    assign valid_o = (count_q != '0);
    assign pop     = pop_i & valid_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push_i, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use <= so all flops update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/sram22_req_ctrl.sv
// Valid/ready front-end for a 256x32 byte-masked SRAM22 macro with a credited read-response FIFO.
module sram22_req_ctrl
    import sram22_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = SRAM22_DATA_W,
    parameter int ADDR_WIDTH  = SRAM22_ADDR_W,
    parameter int WMASK_WIDTH = SRAM22_WMASK_W,
    parameter int RESP_DEPTH  = SRAM22_RESP_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    sram22_req_ctrl_if.slave       bus,
    output logic                   sram_we_o,
    output logic [WMASK_WIDTH-1:0] sram_wmask_o,
    output logic [ADDR_WIDTH-1:0]  sram_addr_o,
    output logic [DATA_WIDTH-1:0]  sram_din_o,
    input  logic [DATA_WIDTH-1:0]  sram_dout_i
);
    localparam int CNT_W  = $clog2(RESP_DEPTH) + 1;
    localparam int USED_W = CNT_W + 1;

    if (DATA_WIDTH != 8 * WMASK_WIDTH) begin : g_bad_mask
        $error("WMASK_WIDTH must be DATA_WIDTH/8");
    end
    if (RESP_DEPTH < 2 || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RESP_DEPTH must be a power of two, at least 2");
    end

    logic              fire;
    logic              wr_fire;
    logic              rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0]  count;
    logic [USED_W-1:0] used;

    assign fire    = bus.req_valid & bus.req_ready;
    assign wr_fire = fire & bus.req_we;

    // Idle cycles still present a read to the macro; that dout is simply never pushed.
    assign sram_addr_o  = bus.req_addr;
    assign sram_din_o   = bus.req_wdata;
    assign sram_we_o    = wr_fire;
    assign sram_wmask_o = wr_fire ? bus.req_wmask : '0;

    // Credit counts the read still in the macro, so ready depends only on registered state.
    assign used          = USED_W'(count) + USED_W'(rd_pend_q);
    assign bus.req_ready = ~rst & (used < USED_W'(RESP_DEPTH));

    assign rd_pend_d = fire & ~bus.req_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_pend_q <= 1'b0;
        else     rd_pend_q <= rd_pend_d;
    end

    sram22_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RESP_DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_pend_q),
        .push_data_i (sram_dout_i),
        .pop_i       (bus.resp_ready),
        .valid_o     (bus.resp_valid),
        .data_o      (bus.resp_rdata),
        .count_o     (count)
    );

endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Scoreboard bench for sram22_req_ctrl with a behavioural SRAM22 macro and an array reference model.
module tb_sram22_req_ctrl;
    import sram22_ctrl_pkg::*;

    localparam int DW    = SRAM22_DATA_W;
    localparam int AW    = SRAM22_ADDR_W;
    localparam int MW    = SRAM22_WMASK_W;
    localparam int DEPTH = SRAM22_RESP_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram22_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    sram22_req_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WMASK_WIDTH(MW),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sram_we_o   (sram_we),
        .sram_wmask_o(sram_wmask),
        .sram_addr_o (sram_addr),
        .sram_din_o  (sram_din),
        .sram_dout_i (sram_dout)
    );

    // Behavioural macro: synchronous byte-masked write, registered read when not writing.
    logic [DW-1:0] sram_mem [256];
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < MW; b++)
                if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
        end else begin
            sram_dout <= sram_mem[sram_addr];
        end
    end

    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            rand_rr  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
            else                   check("resp_data", 64'(bus.resp_rdata), 64'(exp_q.pop_front()));
        end
    end

    function automatic req_t mk(input logic we, input logic [MW-1:0] m,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.we = we; r.wmask = m; r.addr = a; r.wdata = d;
        return r;
    endfunction

    task automatic model_fire(input req_t r);
        if (r.we) begin
            for (int b = 0; b < MW; b++)
                if (r.wmask[b]) ref_mem[r.addr][8*b +: 8] = r.wdata[8*b +: 8];
        end else begin
            exp_q.push_back(ref_mem[r.addr]);
        end
    endtask

    task automatic drive_req(input req_t r, output bit fired);
        bus.req_valid = 1'b1;
        bus.req_we    = r.we;
        bus.req_wmask = r.wmask;
        bus.req_addr  = r.addr;
        bus.req_wdata = r.wdata;
        @(negedge clk);
        fired = bus.req_ready;
        check("sram_we", 64'(sram_we), 64'(fired & r.we));
        check("sram_wmask", 64'(sram_wmask), (fired && r.we) ? 64'(r.wmask) : 64'd0);
        check("sram_addr", 64'(sram_addr), 64'(r.addr));
        if (fired && r.we) check("sram_din", 64'(sram_din), 64'(r.wdata));
        if (fired) model_fire(r);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic send(input req_t r);
        bit f = 0;
        for (int t = 0; t < 50 && !f; t++) begin
            if (rand_rr) bus.resp_ready = 1'($urandom_range(0, 1));
            drive_req(r, f);
        end
        if (!f) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        bus.resp_ready = 1'b1;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            f;
        int            nrd;
        req_t          r;
        logic [AW-1:0] tp_addr [5];

        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_wmask  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        // Reset: even an offered write must not reach the macro.
        repeat (3) @(posedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_wmask = '1;
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_sram_we", 64'(sram_we), 64'd0);
        check("rst_sram_wmask", 64'(sram_wmask), 64'd0);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;

        // Write then read next cycle; response exactly two cycles after the read fires.
        send(mk(1'b1, 4'hF, 8'h10, 32'hDEADBEEF));
        drive_req(mk(1'b0, 4'h0, 8'h10, 32'h0), f);
        check("lat_read_fire", 64'(f), 64'd1);
        @(negedge clk);
        check("lat_cycle1_valid", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(bus.resp_valid), 64'd1);
        check("lat_cycle2_data", 64'(bus.resp_rdata), 64'hDEADBEEF);
        @(posedge clk); #1;
        drain();

        // Partial byte mask merge.
        send(mk(1'b1, 4'hF, 8'h20, 32'h11223344));
        send(mk(1'b1, 4'h5, 8'h20, 32'hAABBCCDD));
        check("ref_mask_merge", 64'(ref_mem[8'h20]), 64'h11BB33DD);
        send(mk(1'b0, 4'h0, 8'h20, 32'h0));
        drain();

        // Backpressure: credit admits exactly DEPTH reads.
        bus.resp_ready = 1'b0;
        nrd = 0;
        for (int k = 0; k < 10; k++) begin
            drive_req(mk(1'b0, 4'h0, AW'(nrd), 32'h0), f);
            if (f) nrd++;
        end
        check("bp_fires", 64'(nrd), 64'(DEPTH));
        @(negedge clk);
        check("bp_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        while (nrd < 8) begin
            send(mk(1'b0, 4'h0, AW'(nrd), 32'h0));
            nrd++;
        end
        drain();

        // Sustained throughput across the top of the address space.
        tp_addr = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00};
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                r = mk(1'b0, 4'h0, tp_addr[k], 32'h0);
                bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = r.addr;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 5) begin
                check("tp_ready", 64'(bus.req_ready), 64'd1);
                if (bus.req_ready) model_fire(r);
            end
            if (k >= 2) check("tp_resp_valid", 64'(bus.resp_valid), 64'd1);
            @(posedge clk); #1;
        end
        drain();

        // Reset with a read in flight drops it; memory survives.
        send(mk(1'b1, 4'hF, 8'h40, 32'hCAFEF00D));
        drive_req(mk(1'b0, 4'h0, 8'h40, 32'h0), f);
        check("rst_inflight_fire", 64'(f), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_inflight_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_inflight_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        check("post_rst_credit", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        send(mk(1'b0, 4'h0, 8'h40, 32'h0));
        check("ref_pre_reset_word", 64'(ref_mem[8'h40]), 64'hCAFEF00D);
        drain();

        // Zero-mask write leaves the word alone.
        send(mk(1'b1, 4'hF, 8'h30, 32'h12345678));
        send(mk(1'b1, 4'h0, 8'h30, 32'hFFFFFFFF));
        send(mk(1'b0, 4'h0, 8'h30, 32'h0));
        drain();

        // Randomized mix with random consumer backpressure.
        rand_rr = 1;
        for (int n = 0; n < 400; n++) begin
            r.we    = 1'($urandom_range(0, 2) == 0);
            r.wmask = MW'($urandom);
            r.addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(240, 255))
                                                   : AW'($urandom_range(0, 15));
            r.wdata = $urandom;
            send(r);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_rr = 0;
        drain();

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
